// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the parity-checked UART link.
//   - uart_state_e : transmitter state encoding (IDLE=0 .. STOP=4, 3 bits)
//   - FRAME_BITS   : bits per frame (start + 8 data + parity + stop)
//   - DATA_BITS    : payload width, fixed at 8 for link compatibility
//   - parity_even  : XOR reduction of one data byte
package uart_pkg;

   localparam int DATA_BITS  = 8;
   localparam int FRAME_BITS = 11;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   // Even parity of one byte: 1 when the byte has an odd number of ones.
   function automatic logic parity_even(input logic [7:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// uart_parity_gen: combinational parity bit for one UART data byte.
// Shared by the transmit and receive ends of the link so both always agree.
// Build option: define UART_TX_PARITY_ODD_EN for odd parity (default is even).
// Ports:
//   data   in  8  byte to protect
//   parity out 1  parity bit to send / expect
module uart_parity_gen (
   input  logic [7:0] data,
   output logic       parity
);
   import uart_pkg::*;

`ifdef UART_TX_PARITY_ODD_EN
   assign parity = ~parity_even(data);
`else
   assign parity = parity_even(data);
`endif

endmodule

// File: rtl/uart_tx_parity.sv
// uart_tx_parity: UART transmitter, frame = start, 8 data bits LSB first,
// parity, stop. One byte is taken per tx_valid/tx_ready handshake.
// Build option: define UART_TX_PARITY_ODD_EN for odd parity (default is even).
// Ports:
//   clk       in   1  system clock, rising edge
//   rst       in   1  synchronous active-high reset (aborts a frame in flight)
//   tx_data   in   8  byte to send, captured on accept
//   tx_valid  in   1  send request
//   tx_ready  out  1  high only while idle
//   tx        out  1  serial line, idles high, driven from a flop
//   busy      out  1  high from the cycle after accept until the frame ends
//   done      out  1  one-cycle pulse in the last cycle of the stop bit
// All outputs are registered: each flop is loaded from the value the
// output must have in the state being entered.
module uart_tx_parity #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = uart_pkg::DATA_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
);
   import uart_pkg::*;

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   uart_state_e            state_r,  state_nxt_s;
   logic [CNT_W-1:0]       cnt_r,    cnt_nxt_s;
   logic [IDX_W-1:0]       idx_r,    idx_nxt_s;
   logic [DATA_BITS-1:0]   shift_r,  shift_nxt_s;
   logic                   par_r,    par_nxt_s;
   logic                   par_in_s;
   logic                   bit_end_s;
   logic                   tx_nxt_s;
   logic                   ready_nxt_s;
   logic                   busy_nxt_s;
   logic                   done_nxt_s;
   logic                   tx_r, ready_r, busy_r, done_r;

   uart_parity_gen u_parity (
      .data   (tx_data),
      .parity (par_in_s)
   );

   assign bit_end_s = (cnt_r == CNT_LAST);

   // Next-state logic: baud counting, bit sequencing and byte capture.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      idx_nxt_s   = idx_r;
      shift_nxt_s = shift_r;
      par_nxt_s   = par_r;
      case (state_r)
         IDLE: begin
            cnt_nxt_s = CNT_ZERO;
            idx_nxt_s = IDX_ZERO;
            if (tx_valid) begin
               // tx_ready is high exactly in IDLE, so tx_valid here is an accept
               shift_nxt_s = tx_data;
               par_nxt_s   = par_in_s;
               state_nxt_s = START;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         START: begin
            if (bit_end_s) begin
               cnt_nxt_s   = CNT_ZERO;
               state_nxt_s = DATA;
            end else begin
               cnt_nxt_s = cnt_r + CNT_ONE;
            end
         end
         DATA: begin
            if (bit_end_s) begin
               cnt_nxt_s   = CNT_ZERO;
               shift_nxt_s = {1'b0, shift_r[DATA_BITS-1:1]};
               if (idx_r == IDX_LAST) begin
                  idx_nxt_s   = IDX_ZERO;
                  state_nxt_s = PARITY;
               end else begin
                  idx_nxt_s = idx_r + IDX_ONE;
               end
            end else begin
               cnt_nxt_s = cnt_r + CNT_ONE;
            end
         end
         PARITY: begin
            if (bit_end_s) begin
               cnt_nxt_s   = CNT_ZERO;
               state_nxt_s = STOP;
            end else begin
               cnt_nxt_s = cnt_r + CNT_ONE;
            end
         end
         STOP: begin
            if (bit_end_s) begin
               cnt_nxt_s   = CNT_ZERO;
               state_nxt_s = IDLE;
            end else begin
               cnt_nxt_s = cnt_r + CNT_ONE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = CNT_ZERO;
            idx_nxt_s   = IDX_ZERO;
         end
      endcase
   end

   // Output decode from the state being entered, so outputs can be registered.
   always_comb begin
      tx_nxt_s = 1'b1;
      case (state_nxt_s)
         IDLE:    tx_nxt_s = 1'b1;
         START:   tx_nxt_s = 1'b0;
         DATA:    tx_nxt_s = shift_nxt_s[0];
         PARITY:  tx_nxt_s = par_nxt_s;
         STOP:    tx_nxt_s = 1'b1;
         default: tx_nxt_s = 1'b1;
      endcase
      ready_nxt_s = (state_nxt_s == IDLE);
      busy_nxt_s  = (state_nxt_s != IDLE);
      // done lands in the cycle where STOP is on its final baud count
      done_nxt_s  = (state_nxt_s == STOP) && (cnt_nxt_s == CNT_LAST);
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         cnt_r   <= CNT_ZERO;
         idx_r   <= IDX_ZERO;
         shift_r <= {DATA_BITS{1'b0}};
         par_r   <= 1'b0;
         tx_r    <= 1'b1;
         ready_r <= 1'b1;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         idx_r   <= idx_nxt_s;
         shift_r <= shift_nxt_s;
         par_r   <= par_nxt_s;
         tx_r    <= tx_nxt_s;
         ready_r <= ready_nxt_s;
         busy_r  <= busy_nxt_s;
         done_r  <= done_nxt_s;
      end
   end

   assign tx       = tx_r;
   assign tx_ready = ready_r;
   assign busy     = busy_r;
   assign done     = done_r;

endmodule

// File: tb/tb_uart_tx_parity.sv
// tb_uart_tx_parity: two transmitters (CLKS_PER_BIT = 4 and 2) compared every
// cycle against a frame-position model, plus literal checks of known frames.
// Cycle numbering: cycle 1 is the first cycle after the accepting clock edge.
module tb_uart_tx_parity;

   logic       clk;
   logic       rst;
   logic [1:0] vld;
   logic [7:0] dat [2];
   logic [1:0] tx_o, rdy_o, busy_o, done_o;

   int total = 0;
   int bad   = 0;
   logic chk_en = 1'b0;

   // model: position inside the frame (-1 = idle) and the frame bits, bit 0 first
   int         m_cpb [2] = '{4, 2};
   int         m_pos [2] = '{-1, -1};
   logic [10:0] m_frame [2];

   logic rec_tx   [1:64];
   logic rec_done [1:64];
   logic [10:0] lit;

   uart_tx_parity #(.CLKS_PER_BIT(4)) dut4 (
      .clk(clk), .rst(rst), .tx_data(dat[0]), .tx_valid(vld[0]),
      .tx_ready(rdy_o[0]), .tx(tx_o[0]), .busy(busy_o[0]), .done(done_o[0])
   );

   uart_tx_parity #(.CLKS_PER_BIT(2)) dut2 (
      .clk(clk), .rst(rst), .tx_data(dat[1]), .tx_valid(vld[1]),
      .tx_ready(rdy_o[1]), .tx(tx_o[1]), .busy(busy_o[1]), .done(done_o[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic model_parity(input logic [7:0] d);
      int ones = 0;
      for (int b = 0; b < 8; b++) ones += int'(d[b]);
`ifdef UART_TX_PARITY_ODD_EN
      return (ones % 2) == 0;
`else
      return (ones % 2) == 1;
`endif
   endfunction

   task automatic chk(input string name, input int inst, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s inst=%0d t=%0t got=%b want=%b", name, inst, $time, act, exp);
      end
   endtask

   // model update on each rising edge from the inputs the DUTs sample
   initial begin
      forever begin
         @(posedge clk);
         for (int i = 0; i < 2; i++) begin
            if (rst) begin
               m_pos[i] = -1;
            end else if (m_pos[i] < 0) begin
               if (vld[i]) begin
                  m_pos[i]   = 0;
                  m_frame[i] = {1'b1, model_parity(dat[i]), dat[i], 1'b0};
               end
            end else begin
               m_pos[i]++;
               if (m_pos[i] == uart_pkg::FRAME_BITS * m_cpb[i]) m_pos[i] = -1;
            end
         end
      end
   end

   // compare every output of both DUTs on every falling edge
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
               int   p;
               logic e_tx;
               p    = m_pos[i];
               e_tx = (p < 0) ? 1'b1 : m_frame[i][p / m_cpb[i]];
               chk("tx",       i, tx_o[i],   e_tx);
               chk("tx_ready", i, rdy_o[i],  p < 0);
               chk("busy",     i, busy_o[i], p >= 0);
               chk("done",     i, done_o[i], p == uart_pkg::FRAME_BITS * m_cpb[i] - 1);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog t=%0t got=running want=finished", $time);
      $fatal(1, "watchdog expired");
   end

   // wait (bounded) for ready, then accept one byte; returns at cycle 1
   task automatic send(input int i, input logic [7:0] d);
      int w = 0;
      while (rdy_o[i] !== 1'b1 && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("ready_wait", i, w < 200, 1'b1);
      vld[i] = 1'b1;
      dat[i] = d;
      @(negedge clk);
      vld[i] = 1'b0;
   endtask

   // record cycles 1..n of instance i; returns at cycle n
   task automatic rec(input int i, input int n);
      for (int k = 1; k <= n; k++) begin
         rec_tx[k]   = tx_o[i];
         rec_done[k] = done_o[i];
         if (k < n) @(negedge clk);
      end
   endtask

   initial begin
      int n_rdy, n_done, first_rdy, k;
      rst = 1'b1;
      vld = 2'b00;
      dat[0] = 8'h00;
      dat[1] = 8'h00;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      // reset state, literal
      chk("rst_tx",    0, tx_o[0],   1'b1);
      chk("rst_ready", 0, rdy_o[0],  1'b1);
      chk("rst_busy",  0, busy_o[0], 1'b0);
      chk("rst_done",  0, done_o[0], 1'b0);
      rst = 1'b0;
      @(negedge clk);

      // basic frame 0xA5 at 4 clocks per bit
`ifdef UART_TX_PARITY_ODD_EN
      lit = 11'b11101001010;
`else
      lit = 11'b10101001010;
`endif
      send(0, 8'hA5);
      rec(0, 44);
      for (int c = 1; c <= 44; c++) begin
         chk("a5_bit",  0, rec_tx[c],   lit[(c - 1) / 4]);
         chk("a5_done", 0, rec_done[c], c == 44);
      end
      @(negedge clk);

      // odd-weight byte 0x01: parity bit occupies cycles 37..40
      send(0, 8'h01);
      rec(0, 44);
      chk("x01_d0", 0, rec_tx[5], 1'b1);
      for (int c = 37; c <= 40; c++) begin
`ifdef UART_TX_PARITY_ODD_EN
         chk("x01_par", 0, rec_tx[c], 1'b0);
`else
         chk("x01_par", 0, rec_tx[c], 1'b1);
`endif
      end
      @(negedge clk);

      // back-to-back with tx_valid held: 0x3C then 0xC3
      send(0, 8'h3C);
      vld[0] = 1'b1;
      dat[0] = 8'hC3;
      n_rdy = 0; n_done = 0; first_rdy = 0;
      for (k = 1; k <= 150; k++) begin
         if (rdy_o[0] && n_done < 2) n_rdy++;
         if (rdy_o[0] && first_rdy == 0) begin
            first_rdy = k;
         end
         if (done_o[0]) n_done++;
         @(negedge clk);
         if (first_rdy != 0) vld[0] = 1'b0;
      end
      chk("b2b_ready_cycles", 0, n_rdy == 1, 1'b1);
      chk("b2b_frames",       0, n_done == 2, 1'b1);
      // second accept edge closes cycle 45
      chk("b2b_second_start", 0, first_rdy == 45, 1'b1);

      // busy ignore: 0xFF pulse during frame 0x00
      send(0, 8'h00);
      n_rdy = 0;
      for (int c = 1; c <= 44; c++) begin
         if (c == 10) begin vld[0] = 1'b1; dat[0] = 8'hFF; end
         if (c == 11) vld[0] = 1'b0;
         if (rdy_o[0]) n_rdy++;
         rec_tx[c] = tx_o[0];
         if (c < 44) @(negedge clk);
      end
      chk("ign_ready", 0, n_rdy == 0, 1'b1);
`ifdef UART_TX_PARITY_ODD_EN
      chk("ign_par", 0, rec_tx[38], 1'b1);
`else
      chk("ign_par", 0, rec_tx[38], 1'b0);
`endif
      chk("ign_d7", 0, rec_tx[33], 1'b0);
      @(negedge clk);

      // reset during data bit 3 (cycles 17..20)
      send(0, 8'h5A);
      repeat (17) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_tx",    0, tx_o[0],   1'b1);
      chk("abort_ready", 0, rdy_o[0],  1'b1);
      chk("abort_busy",  0, busy_o[0], 1'b0);
      n_done = 0;
      for (int c = 0; c < 60; c++) begin
         if (done_o[0]) n_done++;
         @(negedge clk);
      end
      chk("abort_no_done", 0, n_done == 0, 1'b1);
      send(0, 8'h96);
      rec(0, 44);
      for (int c = 1; c <= 44; c++) chk("post_abort_done", 0, rec_done[c], c == 44);
      chk("post_abort_start", 0, rec_tx[1], 1'b0);
      @(negedge clk);

      // divisor edge: 0x80 at 2 clocks per bit
`ifdef UART_TX_PARITY_ODD_EN
      lit = 11'b10100000000;
`else
      lit = 11'b11100000000;
`endif
      send(1, 8'h80);
      rec(1, 22);
      for (int c = 1; c <= 22; c++) begin
         chk("x80_bit",  1, rec_tx[c],   lit[(c - 1) / 2]);
         chk("x80_done", 1, rec_done[c], c == 22);
      end
      @(negedge clk);

      // random traffic on both instances with occasional resets
      for (int c = 0; c < 3000; c++) begin
         vld[0] = ($urandom_range(0, 3) == 0);
         vld[1] = ($urandom_range(0, 3) == 0);
         dat[0] = 8'($urandom);
         dat[1] = 8'($urandom);
         rst    = ($urandom_range(0, 599) == 0);
         @(negedge clk);
      end
      vld = 2'b00;
      rst = 1'b0;
      repeat (60) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
